// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared DMA opcode, arbiter state and timeout definitions
package cnn_pkg;

    typedef enum logic [1:0] {
        RD_WIN  = 2'b00,
        WR_WORD = 2'b01,
        RD_FILT = 2'b10,
        RD_BIAS = 2'b11
    } dma_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_FIN,
        RELEASE
    } arb_state_e;

    localparam int unsigned DMA_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin one-hot selector
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int OW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    last_owner,
    output logic [N_REQ-1:0] pick,
    output logic [OW-1:0]    pick_idx,
    output logic             any
);

    int idx;

    // Scan starts one above the previous owner so the last winner is tried last.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        idx      = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_owner) + i) % N_REQ;
            if (!any && req[OW'(idx)]) begin
                any            = 1'b1;
                pick[OW'(idx)] = 1'b1;
                pick_idx       = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// rtl/dma_arbiter.sv - round-robin arbiter sharing one DMA engine between requesters
module dma_arbiter
    import cnn_pkg::*;
#(
    parameter int          N_REQ   = 3,
    parameter int unsigned TIMEOUT = DMA_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [2*N_REQ-1:0]  req_op,
    input  logic [16*N_REQ-1:0] req_addr,
    input  logic [16*N_REQ-1:0] req_fnum,
    input  logic [16*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  done,
    output logic              err,
    output logic              timeout_sticky,
    output logic              dma_start,
    output logic [1:0]        dma_op,
    output logic [15:0]       dma_addr,
    output logic [15:0]       dma_fnum,
    output logic [15:0]       dma_wdata,
    input  logic              dma_finish
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e       state;
    logic [OW-1:0]    last_owner;
    logic [15:0]      cnt;
    logic [15:0]      cnt_next;
    logic [N_REQ-1:0] pick;
    logic [OW-1:0]    pick_idx;
    logic             any_req;
    dma_op_e          sel_op;
    logic [15:0]      sel_addr;
    logic [15:0]      sel_fnum;
    logic [15:0]      sel_wdata;

    rr_picker #(
        .N_REQ (N_REQ),
        .OW    (OW)
    ) u_picker (
        .req        (req),
        .last_owner (last_owner),
        .pick       (pick),
        .pick_idx   (pick_idx),
        .any        (any_req)
    );

    always_comb begin
        sel_op    = RD_WIN;
        sel_addr  = '0;
        sel_fnum  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                sel_op    = dma_op_e'(req_op[2*i +: 2]);
                sel_addr  = req_addr[16*i +: 16];
                sel_fnum  = req_fnum[16*i +: 16];
                sel_wdata = req_wdata[16*i +: 16];
            end
        end
    end

    assign cnt_next = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            gnt            <= '0;
            done           <= '0;
            err            <= 1'b0;
            timeout_sticky <= 1'b0;
            dma_start      <= 1'b0;
            dma_op         <= RD_WIN;
            dma_addr       <= '0;
            dma_fnum       <= '0;
            dma_wdata      <= '0;
            cnt            <= '0;
            last_owner     <= OW'(N_REQ - 1);
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // A stale finish level from the engine holds off new grants.
                    if (any_req && !dma_finish) begin
                        gnt        <= pick;
                        dma_start  <= 1'b1;
                        dma_op     <= sel_op;
                        dma_addr   <= sel_addr;
                        dma_fnum   <= sel_fnum;
                        dma_wdata  <= sel_wdata;
                        last_owner <= pick_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_FIN;
                end
                WAIT_FIN: begin
                    if (dma_finish) begin
                        dma_start <= 1'b0;
                        done      <= gnt;
                        state     <= RELEASE;
                    end else if ({16'd0, cnt_next} >= TIMEOUT) begin
                        dma_start      <= 1'b0;
                        done           <= gnt;
                        err            <= 1'b1;
                        timeout_sticky <= 1'b1;
                        cnt            <= cnt_next;
                        state          <= RELEASE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                RELEASE: begin
                    gnt <= '0;
                    if (!dma_finish) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of requesters; port 0 = filter/bias loader, 1 = window reader, 2 = result writer.
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles from dma_start rise to dma_finish before abort.
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester transfer request, level.
REQ-006 req_op  input  N_REQ x 2  operation: 00 read window, 01 write word, 10 read filters, 11 read bias.
REQ-007 req_addr  input  N_REQ x 16  RAM base address.
REQ-008 req_fnum  input  N_REQ x 16  filter count (op 10 only).
REQ-009 req_wdata  input  N_REQ x 16  write data (op 01 only).
REQ-010 gnt  output  N_REQ  one-hot, high for the whole owned transfer.
REQ-011 done  output  N_REQ  one-cycle completion pulse to owner.
REQ-012 err  output  1  one-cycle pulse coincident with done when the transfer timed out.
REQ-013 timeout_sticky  output  1  set on any timeout, cleared only by reset.
REQ-014 dma_start, dma_op[1:0], dma_addr[15:0], dma_fnum[15:0], dma_wdata[15:0]  outputs  drive the DMA engine.
REQ-015 dma_finish  input  1  DMA completion level; DMA clears it after dma_start falls.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT_FIN, RELEASE.
REQ-017 IDLE: with any req high, SHALL pick winner round-robin starting one above last_owner, latch its op/addr/fnum/wdata, set gnt and dma_start next cycle, go to ISSUE.
REQ-018 Request-to-dma_start latency SHALL be exactly 1 cycle; payload is sampled only in the grant cycle, later requester changes are ignored.
REQ-019 ISSUE SHALL last one cycle, then WAIT_FIN; dma_start and dma_* payload SHALL stay constant through ISSUE and WAIT_FIN.
REQ-020 WAIT_FIN: on dma_finish==1 SHALL drop dma_start, pulse done[owner] next cycle, go to RELEASE.
REQ-021 Timeout counter (16 bit, saturating) SHALL count WAIT_FIN cycles; on reaching TIMEOUT SHALL drop dma_start, pulse done[owner] and err, set timeout_sticky, go to RELEASE.
REQ-022 RELEASE: gnt SHALL clear; SHALL stay until dma_finish==0, then IDLE; minimum 1 cycle, so back-to-back transfers have ≥2 idle cycles between dma_start pulses.
REQ-023 last_owner SHALL update at grant; after reset last_owner = N_REQ-1, so requester 0 wins first tie.
REQ-024 A req dropped after grant SHALL NOT abort the transfer; done still pulses.
REQ-025 A requester whose req stays high after done SHALL be re-arbitrated fairly, not re-granted ahead of other pending requesters.
REQ-026 dma_finish high while IDLE SHALL be ignored and SHALL block grants until it falls.
REQ-027 Payload outputs SHALL hold last value when idle; only dma_start qualifies them.

Reset
REQ-028 Reset SHALL force IDLE, gnt=0, done=0, err=0, timeout_sticky=0, dma_start=0, dma_op=0, dma_addr=0, dma_fnum=0, dma_wdata=0, counter=0, last_owner=N_REQ-1, immediately and regardless of clk.
REQ-029 Reset mid-transfer SHALL drop dma_start at once; no done pulse for the aborted transfer.

Structure
REQ-030 Shared package cnn_pkg SHALL hold the dma_op_e enum (RD_WIN, WR_WORD, RD_FILT, RD_BIAS), state enum, and DMA_TIMEOUT_DEFAULT.
REQ-031 One sub-module rr_picker (combinational N_REQ round-robin one-hot selector from req and last_owner) SHALL be instantiated.

Verification
REQ-032 req=3'b100, op=01, addr=0x0040, wdata=0x1234; dma_finish high 5 cycles after start -> dma_start 1 cycle after req, dma_addr=0x0040, dma_wdata=0x1234, done[2] one cycle after finish.
REQ-033 req=3'b111 held, DMA finishes each in 3 cycles -> grants in order 0,1,2,0, each done single-cycle, ≥2 idle cycles between dma_start pulses.
REQ-034 req=3'b001, op=10, fnum=6; dma_finish never rises, TIMEOUT=16 -> dma_start falls after 16 WAIT_FIN cycles, done[0]+err pulse, timeout_sticky=1.
REQ-035 Reset asserted asynchronously mid-WAIT_FIN -> dma_start and gnt low before next clk edge, no done pulse, first post-reset grant goes to port 0.
REQ-036 dma_finish held high 4 cycles after start falls, req[1] pending -> no grant until finish low, then gnt[1] next cycle.
